// File: rtl/loa_sub_32bits_pipe_if.sv
// Handshake and data bundle for the pipelined approximate subtractor:
// an upstream valid/ready operand channel and a downstream valid/ready result channel.
interface loa_sub_32bits_pipe_if;
  localparam int unsigned DATA_W = 32;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              in_exact;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_diff;
  logic              out_borrow;

  modport master (
    output in_valid, in_a, in_b, in_exact, out_ready,
    input  in_ready, out_valid, out_diff, out_borrow
  );

  modport slave (
    input  in_valid, in_a, in_b, in_exact, out_ready,
    output in_ready, out_valid, out_diff, out_borrow
  );
endinterface

// File: rtl/loa_sub_32bits_pipe.sv
// Two-stage 32-bit subtractor: OR-approximated (or exact) lower part in stage 1,
// exact upper add with borrow in stage 2, valid/ready flow control on both sides.
module loa_sub_32bits_pipe #(
  parameter int unsigned APPROX_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  loa_sub_32bits_pipe_if.slave bus
);
  localparam int unsigned W   = 32;
  localparam int unsigned LW  = APPROX_BITS;
  localparam int unsigned UW  = W - LW;
  localparam int unsigned LW1 = LW + 1;
  localparam int unsigned UW1 = UW + 1;

  logic          s1_valid_q, s1_valid_d;
  logic [LW-1:0] s1_low_q, s1_low_d;
  logic          s1_cl_q, s1_cl_d;
  logic [UW-1:0] s1_a_hi_q, s1_a_hi_d;
  logic [UW-1:0] s1_nb_hi_q, s1_nb_hi_d;
  logic          s2_valid_q, s2_valid_d;
  logic [W-1:0]  s2_diff_q, s2_diff_d;
  logic          s2_borrow_q, s2_borrow_d;

  logic          s1_advance_c;
  logic          accept_c;
  logic [W-1:0]  nb_c;
  logic [LW:0]   low_exact_c;
  logic [UW:0]   upper_c;

  // Stage 1 may move on whenever stage 2 is free or draining this cycle.
  always_comb begin
    s1_advance_c = s1_valid_q & (~s2_valid_q | bus.out_ready);
    accept_c     = bus.in_valid & (~s1_valid_q | s1_advance_c);
    nb_c         = ~bus.in_b;
    low_exact_c  = LW1'(bus.in_a[LW-1:0]) + LW1'(nb_c[LW-1:0]) + LW1'(1);
    upper_c      = UW1'(s1_a_hi_q) + UW1'(s1_nb_hi_q) + UW1'(s1_cl_q);

    s1_valid_d  = s1_valid_q;
    s1_low_d    = s1_low_q;
    s1_cl_d     = s1_cl_q;
    s1_a_hi_d   = s1_a_hi_q;
    s1_nb_hi_d  = s1_nb_hi_q;
    s2_valid_d  = s2_valid_q;
    s2_diff_d   = s2_diff_q;
    s2_borrow_d = s2_borrow_q;

    if (accept_c) begin
      s1_valid_d = 1'b1;
      s1_a_hi_d  = bus.in_a[W-1:LW];
      s1_nb_hi_d = nb_c[W-1:LW];
      if (bus.in_exact) begin
        s1_low_d = low_exact_c[LW-1:0];
        s1_cl_d  = low_exact_c[LW];
      end else begin
        // The two's-complement +1 is dropped; the top approximate bit feeds the carry.
        s1_low_d = bus.in_a[LW-1:0] | nb_c[LW-1:0];
        s1_cl_d  = bus.in_a[LW-1] | nb_c[LW-1];
      end
    end else if (s1_advance_c) begin
      s1_valid_d = 1'b0;
    end

    if (s1_advance_c) begin
      s2_valid_d  = 1'b1;
      s2_diff_d   = {upper_c[UW-1:0], s1_low_q};
      s2_borrow_d = ~upper_c[UW];
    end else if (bus.out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_low_q    <= '0;
      s1_cl_q     <= 1'b0;
      s1_a_hi_q   <= '0;
      s1_nb_hi_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_diff_q   <= '0;
      s2_borrow_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_low_q    <= s1_low_d;
      s1_cl_q     <= s1_cl_d;
      s1_a_hi_q   <= s1_a_hi_d;
      s1_nb_hi_q  <= s1_nb_hi_d;
      s2_valid_q  <= s2_valid_d;
      s2_diff_q   <= s2_diff_d;
      s2_borrow_q <= s2_borrow_d;
    end
  end

  assign bus.in_ready   = ~s1_valid_q | s1_advance_c;
  assign bus.out_valid  = s2_valid_q;
  assign bus.out_diff   = s2_diff_q;
  assign bus.out_borrow = s2_borrow_q;
endmodule

// File: tb/tb_loa_sub_32bits_pipe.sv
// Bench for loa_sub_32bits_pipe: directed and random transactions checked against
// an arithmetic reference model through an in-order expected-result queue.
module tb_loa_sub_32bits_pipe;
  localparam int unsigned L = 8;

  typedef struct packed {
    logic [31:0] diff;
    logic        borrow;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  loa_sub_32bits_pipe_if bus ();
  loa_sub_32bits_pipe #(.APPROX_BITS(L)) dut (.clk(clk), .rst(rst), .bus(bus));

  res_t exp_q[$];
  res_t pending;
  int   errors = 0;
  int   checks = 0;
  int   n_out  = 0;

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic exact);
    res_t            r;
    logic [31:0]     nb32;
    longint unsigned nb, low, cl, up;
    if (exact) begin
      r.diff   = a - b;
      r.borrow = (a < b);
    end else begin
      nb32     = ~b;
      nb       = nb32;
      low      = (a | nb) & ((64'd1 << L) - 1);
      cl       = ((a | nb) >> (L - 1)) & 1;
      up       = (a >> L) + (nb >> L) + cl;
      r.diff   = 32'((up << L) | low);
      r.borrow = (((up >> (32 - L)) & 1) == 0);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic ex, input res_t e);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_exact = ex;
    bus.in_valid = 1'b1;
    pending      = e;
  endtask

  task automatic drive_rand();
    logic [31:0] a, b;
    logic        ex;
    a  = $urandom;
    b  = $urandom;
    ex = 1'($urandom_range(0, 1));
    drive(a, b, ex, model(a, b, ex));
  endtask

  // Evaluate this cycle's transfers just before the rising edge, then advance one cycle.
  task automatic step();
    res_t e;
    #1;
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_out: observed diff %0h with no result outstanding", bus.out_diff);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_diff", 64'(bus.out_diff), 64'(e.diff));
          check("out_borrow", 64'(bus.out_borrow), 64'(e.borrow));
          n_out++;
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(pending);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
    check("drain_left", 64'(exp_q.size()), 64'd0);
    step();
    check("idle_valid", 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    int n0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_exact  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_diff", 64'(bus.out_diff), 64'd0);
    check("rst_out_borrow", 64'(bus.out_borrow), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Exact mode with latency check, including wrap-around.
    bus.out_ready = 1'b1;
    drive(32'h5, 32'h3, 1'b1, res_t'{32'h2, 1'b0});
    step();
    check("lat_cycle1", 64'(bus.out_valid), 64'd0);
    drive(32'h0, 32'h1, 1'b1, res_t'{32'hFFFF_FFFF, 1'b1});
    step();
    check("lat_cycle2", 64'(bus.out_valid), 64'd1);
    drain();

    // Approximate mode and the exact counterpart of the same pair.
    drive(32'h5, 32'h3, 1'b0, res_t'{32'h0000_00FD, 1'b0});
    step();
    drive(32'h100, 32'h1, 1'b0, res_t'{32'h0000_01FE, 1'b0});
    step();
    drive(32'h100, 32'h1, 1'b1, res_t'{32'h0000_00FF, 1'b0});
    step();
    drain();

    // Streaming: one result per cycle once the pipe is primed.
    n0 = n_out;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive_rand();
      #1;
      check("stream_in_ready", 64'(bus.in_ready), 64'd1);
      step();
    end
    check("stream_count", 64'(n_out - n0), 64'd98);
    drain();

    // Backpressure: two accepts fill the pipe, then hold.
    bus.out_ready = 1'b0;
    drive_rand();
    step();
    drive_rand();
    step();
    drive_rand();
    #1;
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_diff", 64'(bus.out_diff), 64'(exp_q[0].diff));
      check("hold_borrow", 64'(bus.out_borrow), 64'(exp_q[0].borrow));
      step();
    end
    // Consume and accept in the same cycle while full.
    bus.out_ready = 1'b1;
    #1;
    check("shift_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("shift_occ_valid", 64'(bus.out_valid), 64'd1);
    check("shift_occ_ready", 64'(bus.in_ready), 64'd0);
    check("shift_queue", 64'(exp_q.size()), 64'd2);
    drain();

    // Reset with both stages valid and a new input offered in the same cycle.
    bus.out_ready = 1'b0;
    drive_rand();
    step();
    drive_rand();
    step();
    rst = 1'b1;
    drive_rand();
    step();
    rst = 1'b0;
    exp_q.delete();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_diff", 64'(bus.out_diff), 64'd0);
    check("mid_rst_borrow", 64'(bus.out_borrow), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("no_stale", 64'(bus.out_valid), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
